// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  // addi x0, x0, 0
  localparam word_t INST_NOP = 32'h0000_0013;

  // One fetch-queue slot: fetch address, returned word, and whether it has returned yet.
  typedef struct packed {
    word_t pc;
    word_t inst;
    logic  filled;
  } fq_entry_t;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic word_t next_pc(input word_t pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Controller, instruction-memory and ID-side signals of the fetch stage.
interface if_stage_if;
  import if_stage_pkg::*;

  logic  pause;
  logic  flush;
  word_t flush_target;

  logic  imem_req_valid;
  word_t imem_req_addr;
  logic  imem_req_ready;
  logic  imem_resp_valid;
  word_t imem_resp_data;

  logic  id_valid;
  word_t id_pc;
  word_t id_inst;

  modport master (
    input  pause, flush, flush_target,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output imem_req_valid, imem_req_addr,
    output id_valid, id_pc, id_inst
  );

  modport slave (
    output pause, flush, flush_target,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  imem_req_valid, imem_req_addr,
    input  id_valid, id_pc, id_inst
  );

endinterface

// File: rtl/if_stage_fetch_queue.sv
// Circular queue of in-order fetches: allocated at request, filled at response, popped by ID.
module fetch_queue
  import if_stage_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             alloc_i,
  input  word_t            alloc_pc_i,
  input  logic             fill_i,
  input  word_t            fill_inst_i,
  input  logic             pop_i,
  output logic             head_filled_o,
  output word_t            head_pc_o,
  output word_t            head_inst_o,
  output logic [CNT_W-1:0] alloc_cnt_o,
  output logic [CNT_W-1:0] unfilled_cnt_o
);

  fq_entry_t        entry_q [DEPTH];
  fq_entry_t        entry_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CNT_W-1:0] alloc_cnt_q, alloc_cnt_d, unfilled_cnt_q, unfilled_cnt_d;

  // Next-state: clear wins; otherwise alloc at tail, fill oldest unfilled, pop head.
  always_comb begin
    entry_d        = entry_q;
    head_d         = head_q;
    tail_d         = tail_q;
    fill_d         = fill_q;
    alloc_cnt_d    = alloc_cnt_q;
    unfilled_cnt_d = unfilled_cnt_q;
    if (clear_i) begin
      head_d         = '0;
      tail_d         = '0;
      fill_d         = '0;
      alloc_cnt_d    = '0;
      unfilled_cnt_d = '0;
      for (int i = 0; i < DEPTH; i++) entry_d[i].filled = 1'b0;
    end else begin
      if (alloc_i) begin
        entry_d[tail_q] = '{pc: alloc_pc_i, inst: INST_NOP, filled: 1'b0};
        tail_d          = tail_q + PTR_W'(1);
      end
      if (fill_i) begin
        entry_d[fill_q].inst   = fill_inst_i;
        entry_d[fill_q].filled = 1'b1;
        fill_d                 = fill_q + PTR_W'(1);
      end
      if (pop_i) head_d = head_q + PTR_W'(1);
      alloc_cnt_d    = alloc_cnt_q + CNT_W'(alloc_i) - CNT_W'(pop_i);
      unfilled_cnt_d = unfilled_cnt_q + CNT_W'(alloc_i) - CNT_W'(fill_i);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '{pc: '0, inst: INST_NOP, filled: 1'b0};
      head_q         <= '0;
      tail_q         <= '0;
      fill_q         <= '0;
      alloc_cnt_q    <= '0;
      unfilled_cnt_q <= '0;
    end else begin
      entry_q        <= entry_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      fill_q         <= fill_d;
      alloc_cnt_q    <= alloc_cnt_d;
      unfilled_cnt_q <= unfilled_cnt_d;
    end
  end

  // Head view; a slot freed by pop keeps a stale filled bit, so gate on occupancy.
  assign head_filled_o  = (alloc_cnt_q != '0) && entry_q[head_q].filled;
  assign head_pc_o      = entry_q[head_q].pc;
  assign head_inst_o    = entry_q[head_q].inst;
  assign alloc_cnt_o    = alloc_cnt_q;
  assign unfilled_cnt_o = unfilled_cnt_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, memory request issue, stale-response drop and ID handoff.
module if_stage
  import if_stage_pkg::*;
#(
  parameter word_t       RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic clk,
  input  logic rst,
  if_stage_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  word_t            pc_q, pc_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] alloc_cnt, unfilled_cnt;
  logic             head_filled;
  word_t            head_pc, head_inst;

  logic             id_valid_c, pop_c, req_valid_c, accept_c, fill_c;
  logic [OCC_W-1:0] occ_c, owed_c;

  // Handshake decode: slots in use (queue + owed stale responses) gate new requests.
  always_comb begin
    id_valid_c  = rst & head_filled;
    pop_c       = id_valid_c & ~bus.pause & ~bus.flush;
    occ_c       = OCC_W'(alloc_cnt) + OCC_W'(drop_q) - OCC_W'(pop_c);
    req_valid_c = rst & ~bus.flush & (occ_c < OCC_W'(DEPTH));
    accept_c    = req_valid_c & bus.imem_req_ready;
    fill_c      = bus.imem_resp_valid & ~bus.flush & (drop_q == '0) & (unfilled_cnt != '0);
  end

  // PC and drop-count next state; a flush converts every unreturned fetch into a drop.
  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    owed_c = OCC_W'(unfilled_cnt) + OCC_W'(drop_q);
    if (bus.flush) begin
      pc_d = bus.flush_target;
      if (bus.imem_resp_valid && (owed_c != '0)) owed_c = owed_c - OCC_W'(1);
      drop_d = CNT_W'(owed_c);
    end else begin
      if (accept_c) pc_d = next_pc(pc_q);
      if (bus.imem_resp_valid && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
    end
  end

  // PC and drop registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_fetch_queue (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (bus.flush),
    .alloc_i       (accept_c),
    .alloc_pc_i    (pc_q),
    .fill_i        (fill_c),
    .fill_inst_i   (bus.imem_resp_data),
    .pop_i         (pop_c),
    .head_filled_o (head_filled),
    .head_pc_o     (head_pc),
    .head_inst_o   (head_inst),
    .alloc_cnt_o   (alloc_cnt),
    .unfilled_cnt_o(unfilled_cnt)
  );

  assign bus.imem_req_valid = req_valid_c;
  assign bus.imem_req_addr  = pc_q;
  assign bus.id_valid       = id_valid_c;
  assign bus.id_pc          = id_valid_c ? head_pc : '0;
  assign bus.id_inst        = id_valid_c ? head_inst : INST_NOP;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed pause/flush/reset schedule against a latency memory model.
module tb_if_stage;
  import if_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  if_stage_if bus();

  if_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_addr[$];
  int          mem_due[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs at negedge, present due response, record acceptance.
  task automatic tick(input logic r, input logic p, input logic f, input logic [31:0] tgt,
                      input logic rdy, input int lat);
    @(negedge clk);
    rst                = r;
    bus.pause          = p;
    bus.flush          = f;
    bus.flush_target   = tgt;
    bus.imem_req_ready = rdy;
    if (!r) begin
      mem_addr.delete();
      mem_due.delete();
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'hDEAD_BEEF;
    end else if (mem_addr.size() > 0 && mem_due[0] <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_addr.pop_front();
      void'(mem_due.pop_front());
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'hDEAD_BEEF;
    end
    #1;
    if (r && bus.imem_req_valid && rdy) begin
      mem_addr.push_back(bus.imem_req_addr);
      mem_due.push_back(cyc + lat);
    end
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // Monitor: every instruction ID consumes must be the next expected one (memory returns inst = addr).
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && bus.id_valid && !bus.pause && !bus.flush) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_id_pc", bus.id_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("id_pc", bus.id_pc, e);
          chk("id_inst", bus.id_inst, e);
        end
      end else if (!bus.id_valid) begin
        chk("idle_nop", bus.id_inst, INST_NOP);
      end
      chk("outstanding_le_2", (mem_addr.size() <= 2) ? 32'd1 : 32'd0, 32'd1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.pause = 1'b0; bus.flush = 1'b0; bus.flush_target = '0;
    bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0; bus.imem_resp_data = '0;

    tick(1'b0, 1'b0, 1'b0, '0, 1'b1, 1);
    tick(1'b0, 1'b0, 1'b0, '0, 1'b1, 1);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_id_pc", bus.id_pc, 32'd0);
    chk("rst_id_inst", bus.id_inst, INST_NOP);

    // Cycle-exact schedule: pause 4..6, quiesce 12..14, flush 15 (->0x300), 18 (->0x100), 35 (->0x400).
    push_seq(32'h0, 7);
    for (int k = 0; k <= 41; k++) begin
      logic        p, f;
      logic [31:0] tgt;
      int          lat;
      p   = (k >= 4 && k <= 6) || (k >= 12 && k <= 15);
      f   = (k == 15) || (k == 18) || (k == 35);
      tgt = (k == 15) ? 32'h300 : (k == 18) ? 32'h100 : (k == 35) ? 32'h400 : 32'h0;
      lat = (k < 12) ? 1 : 3;
      if (k == 15) push_seq(32'h100, 6);
      if (k == 35) push_seq(32'h400, 10);
      tick(1'b1, p, f, tgt, 1'b1, lat);
      case (k)
        0:  begin chk("c0_req_valid", 32'(bus.imem_req_valid), 32'd1);
                  chk("c0_req_addr", bus.imem_req_addr, 32'h0); end
        1:  chk("c1_id_valid", 32'(bus.id_valid), 32'd0);
        2:  chk("c2_id_valid", 32'(bus.id_valid), 32'd1);
        5:  chk("pause_full_req", 32'(bus.imem_req_valid), 32'd0);
        15: chk("flush_no_req", 32'(bus.imem_req_valid), 32'd0);
        16: begin chk("post_flush_req", 32'(bus.imem_req_valid), 32'd1);
                  chk("post_flush_addr", bus.imem_req_addr, 32'h300); end
        19: chk("drop_blocks_req", 32'(bus.imem_req_valid), 32'd0);
        20: begin chk("redirect_req", 32'(bus.imem_req_valid), 32'd1);
                  chk("redirect_addr", bus.imem_req_addr, 32'h100); end
        26: chk("c26_id_valid", 32'(bus.id_valid), 32'd0);
        35: chk("flush_with_resp", 32'(bus.imem_resp_valid), 32'd1);
        default: ;
      endcase
    end

    // Ready toggling 1-0-1 with 3-cycle memory until the expected stream drains.
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0) break;
      tick(1'b1, 1'b0, 1'b0, '0, (k % 2) == 0, 3);
      #2;
    end
    chk("drain_ready_toggle", 32'(exp_q.size()), 32'd0);

    // One-cycle reset in the middle of a stream.
    tick(1'b0, 1'b0, 1'b0, '0, 1'b1, 1);
    chk("mid_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("mid_rst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("mid_rst_id_pc", bus.id_pc, 32'd0);
    chk("mid_rst_id_inst", bus.id_inst, INST_NOP);
    push_seq(32'h0, 4);
    tick(1'b1, 1'b0, 1'b0, '0, 1'b1, 1);
    chk("restart_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("restart_req_addr", bus.imem_req_addr, 32'h0);
    #2;
    for (int k = 0; k < 50; k++) begin
      if (exp_q.size() == 0) break;
      tick(1'b1, 1'b0, 1'b0, '0, 1'b1, 1);
      #2;
    end
    chk("drain_restart", 32'(exp_q.size()), 32'd0);

    tick(1'b1, 1'b1, 1'b0, '0, 1'b1, 1);
    tick(1'b1, 1'b1, 1'b0, '0, 1'b1, 1);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
